rr_pop_scheduler: RTL and testbench
===================================

RR_POP_SCHEDULER -- requirements
Module: rr_pop_scheduler

Interface
REQ-001 The module SHALL have parameter QUEUE_QUANTITY, default 4, the number of FIFO queues served.
REQ-002 The module SHALL have parameter DATA_BITS, default 8, the width of one FIFO word.
REQ-003 Derived width SW = $clog2(QUEUE_QUANTITY) SHALL be used for all queue indices.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port enb, input, 1 bit: scheduler enable.
REQ-007 The module SHALL have port buf_empty, input, QUEUE_QUANTITY bits: per-queue FIFO empty flags.
REQ-008 The module SHALL have port fifo_data, input, QUEUE_QUANTITY*DATA_BITS bits: show-ahead head word of each queue, with queue i at bits [i*DATA_BITS +: DATA_BITS].
REQ-009 The module SHALL have port selector, input, SW bits: queue chosen by the round-robin interface.
REQ-010 The module SHALL have port selector_enb, input, 1 bit: selector is valid.
REQ-011 The module SHALL have port modo_req, input, 2 bits: requested arbitration mode (00/11 regular, 01 weighted, 10 table).
REQ-012 The module SHALL have port modo_req_valid, input, 1 bit: single-cycle mode-change request strobe.
REQ-013 The module SHALL have port ready_in, input, 1 bit: downstream ready.
REQ-014 The module SHALL have port arb_enb, output, 1 bit: enable to the round-robin interface.
REQ-015 The module SHALL have port seleccion_roundRobin, output, 2 bits: mode driven to the round-robin interface.
REQ-016 The module SHALL have port pop, output, QUEUE_QUANTITY bits: one-hot FIFO pop strobe.
REQ-017 The module SHALL have port data_out, output, DATA_BITS bits: the popped word.
REQ-018 The module SHALL have port valid_out, output, 1 bit: data_out is valid.
REQ-019 The module SHALL have port modo_ack, output, 1 bit: one-cycle pulse when a new mode is applied.
REQ-020 The module SHALL have port pop_count, output, 16 bits: total pops since reset, wrapping at 2^16.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, GRANT, POP, HOLD and RECONF.
REQ-022 In IDLE, the FSM SHALL go to RECONF if pend is set; otherwise to GRANT if enb=1 and buf_empty is not all ones; otherwise it SHALL stay in IDLE.
REQ-023 arb_enb SHALL be 1 only in GRANT.
REQ-024 In GRANT with selector_enb=1, the module SHALL latch selector into sel_q and go to POP.
REQ-025 In GRANT, if selector_enb=0 or enb=0, the FSM SHALL go to IDLE.
REQ-026 In POP with buf_empty[sel_q]=0, the module SHALL assert pop[sel_q] for exactly that cycle.
REQ-027 In that same POP cycle, the module SHALL register fifo_data slice sel_q into data_out, set valid_out, increment pop_count and go to HOLD.
REQ-028 In POP with buf_empty[sel_q]=1, the module SHALL assert no pop, leave pop_count unchanged and go to GRANT.
REQ-029 In HOLD, valid_out and data_out SHALL stay stable until ready_in=1.
REQ-030 On leaving HOLD (ready_in=1), the module SHALL clear valid_out and go to RECONF if pend is set, else to GRANT if enb=1 and any queue is non-empty, else to IDLE.
REQ-031 A modo_req_valid pulse in any state SHALL set pend and store modo_req in modo_pend; if several pulses arrive before it is applied, the latest one wins.
REQ-032 A mode change SHALL NOT take effect during GRANT, POP or HOLD.
REQ-033 RECONF SHALL last one cycle, in which it loads seleccion_roundRobin from modo_pend, pulses modo_ack, clears pend (unless a new modo_req_valid arrives in the same cycle) and returns to IDLE.
REQ-034 Deasserting enb SHALL NOT abort a word in POP or HOLD; the word SHALL complete its handshake.
REQ-035 Latency SHALL be: IDLE with data and enb=1 -> pop in cycle 2 -> valid_out=1 in cycle 3; with ready_in held high, sustained throughput is one word per 3 cycles.
REQ-036 pop SHALL be one-hot or zero in every cycle.
REQ-037 pop_count SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-038 When rst=0 at a clock edge, the module SHALL enter IDLE and clear sel_q, pend and modo_pend.
REQ-039 On that reset, every output SHALL go to zero: arb_enb=0, seleccion_roundRobin=2'b00, pop=0, data_out=0, valid_out=0, modo_ack=0, pop_count=0.
REQ-040 A reset asserted in HOLD SHALL drop valid_out in the next cycle, and the word SHALL be discarded.

Verification
REQ-041 Queue 2 only non-empty, selector=2, selector_enb=1, ready_in=1 -> pop=4'b0100 in cycle 2, valid_out=1 with data_out = queue-2 word in cycle 3, pop_count=1.
REQ-042 ready_in=0 for 5 cycles in HOLD -> data_out and valid_out stay stable, no further pop, arb_enb=0.
REQ-043 modo_req=2'b01 pulsed during HOLD -> seleccion_roundRobin stays 00 until the handshake completes, then becomes 01 in the RECONF cycle with modo_ack=1 for one cycle.
REQ-044 buf_empty[sel_q] rises between GRANT and POP -> pop stays 0, FSM returns to GRANT, pop_count unchanged.
REQ-045 rst=0 while in HOLD -> all outputs are zero on the next cycle and the FSM is in IDLE.
REQ-046 Preload pop_count to 0xFFFF, then one pop -> pop_count=0x0000.

Source files
------------

// File: rtl/rr_pop_scheduler.sv
// Pops one word at a time from the queue picked by an external round-robin arbiter,
// holds it until downstream accepts, and applies arbitration-mode changes only between words.
module rr_pop_scheduler #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  localparam int SW            = $clog2(QUEUE_QUANTITY)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
  input  logic [SW-1:0]                       selector,
  input  logic                                selector_enb,
  input  logic [1:0]                          modo_req,
  input  logic                                modo_req_valid,
  input  logic                                ready_in,
  output logic                                arb_enb,
  output logic [1:0]                          seleccion_roundRobin,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                valid_out,
  output logic                                modo_ack,
  output logic [15:0]                         pop_count
);

  typedef enum logic [2:0] {IDLE, GRANT, POP, HOLD, RECONF} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [SW-1:0]        r_sel_q;
  logic                 r_pend;
  logic [1:0]           r_modo_pend;
  logic [1:0]           r_mode;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic [15:0]          r_pop_count;
  logic                 w_any_data;
  logic                 w_head_empty;
  logic [DATA_BITS-1:0] w_head_word;
  logic                 w_do_pop;

  assign w_any_data   = ~&buf_empty;
  assign w_head_empty = buf_empty[r_sel_q];
  assign w_head_word  = fifo_data[r_sel_q*DATA_BITS +: DATA_BITS];

  always_comb begin
    w_state_next = r_state;
    w_do_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend)                  w_state_next = RECONF;
        else if (enb && w_any_data)  w_state_next = GRANT;
      end
      GRANT: begin
        if (enb && selector_enb)     w_state_next = POP;
        else                         w_state_next = IDLE;
      end
      // The head can vanish between grant and pop; retry arbitration instead of popping air.
      POP: begin
        if (!w_head_empty) begin
          w_do_pop     = 1'b1;
          w_state_next = HOLD;
        end else begin
          w_state_next = GRANT;
        end
      end
      HOLD: begin
        if (ready_in) begin
          if (r_pend)                  w_state_next = RECONF;
          else if (enb && w_any_data)  w_state_next = GRANT;
          else                         w_state_next = IDLE;
        end
      end
      RECONF:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_sel_q     <= '0;
      r_pend      <= 1'b0;
      r_modo_pend <= 2'b00;
      r_mode      <= 2'b00;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_pop_count <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      if (r_state == GRANT && enb && selector_enb) r_sel_q <= selector;
      if (w_do_pop) begin
        r_data      <= w_head_word;
        r_valid     <= 1'b1;
        r_pop_count <= r_pop_count + 16'd1;
      end
      if (r_state == HOLD && ready_in) r_valid <= 1'b0;
      if (r_state == RECONF) r_mode <= r_modo_pend;
      // A request landing in the RECONF cycle stays pending for the next reconfiguration.
      if (modo_req_valid) begin
        r_pend      <= 1'b1;
        r_modo_pend <= modo_req;
      end else if (r_state == RECONF) begin
        r_pend <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_pop
    assign pop[gi] = w_do_pop && (r_sel_q == SW'(gi));
  end

  assign arb_enb              = (r_state == GRANT);
  assign modo_ack             = (r_state == RECONF);
  assign seleccion_roundRobin = (r_state == RECONF) ? r_modo_pend : r_mode;
  assign data_out             = r_data;
  assign valid_out            = r_valid;
  assign pop_count            = r_pop_count;

endmodule

// File: tb/tb_rr_pop_scheduler.sv
// Self-checking bench for rr_pop_scheduler: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_rr_pop_scheduler;

  localparam int QN = 4;
  localparam int DB = 8;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enb = 1'b0;
  logic [QN-1:0]    buf_empty = '1;
  logic [QN*DB-1:0] fifo_data = '0;
  logic [SW-1:0]    selector = '0;
  logic             selector_enb = 1'b0;
  logic [1:0]       modo_req = 2'b00;
  logic             modo_req_valid = 1'b0;
  logic             ready_in = 1'b0;
  logic             arb_enb;
  logic [1:0]       seleccion_roundRobin;
  logic [QN-1:0]    pop;
  logic [DB-1:0]    data_out;
  logic             valid_out;
  logic             modo_ack;
  logic [15:0]      pop_count;

  rr_pop_scheduler #(.QUEUE_QUANTITY(QN), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .enb(enb), .buf_empty(buf_empty), .fifo_data(fifo_data),
    .selector(selector), .selector_enb(selector_enb), .modo_req(modo_req),
    .modo_req_valid(modo_req_valid), .ready_in(ready_in), .arb_enb(arb_enb),
    .seleccion_roundRobin(seleccion_roundRobin), .pop(pop), .data_out(data_out),
    .valid_out(valid_out), .modo_ack(modo_ack), .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_count = 16'h0000;
  logic [1:0]  exp_mode = 2'b00;
  logic [DB-1:0] words [QN];

  task automatic load_words();
    for (int i = 0; i < QN; i++) begin
      words[i] = DB'($urandom);
      fifo_data[i*DB +: DB] = words[i];
    end
  endtask

  // Drives a grant for queue q and returns at the negedge of the HOLD cycle.
  task automatic start_txn(input int q);
    logic [QN-1:0] oh;
    oh = '0;
    oh[q] = 1'b1;
    load_words();
    buf_empty = QN'($urandom) & ~oh;
    selector = SW'(q);
    selector_enb = 1'b1;
    enb = 1'b1;
    ready_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (arb_enb !== 1'b0) begin failures++; $display("FAIL reset_arb_enb got=%0b exp=0", arb_enb); end
    checks++; if (pop !== '0) begin failures++; $display("FAIL reset_pop got=%b exp=0000", pop); end
    checks++; if (valid_out !== 1'b0 || data_out !== '0) begin failures++; $display("FAIL reset_data got=%0b/%h exp=0/00", valid_out, data_out); end
    checks++; if (pop_count !== 16'h0 || modo_ack !== 1'b0 || seleccion_roundRobin !== 2'b00) begin
      failures++; $display("FAIL reset_misc got=%h/%0b/%b exp=0000/0/00", pop_count, modo_ack, seleccion_roundRobin); end
    rst = 1'b1;
    exp_count = 16'h0;
    exp_mode = 2'b00;
    @(negedge clk);
    $display("txn reset done");
  endtask

  task automatic test_single_queue2();
    load_words();
    buf_empty = 4'b1011;
    selector = 2'd2;
    selector_enb = 1'b1;
    enb = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    checks++; if (arb_enb !== 1'b1 || pop !== '0) begin failures++; $display("FAIL q2_grant got=%0b/%b exp=1/0000", arb_enb, pop); end
    @(negedge clk);
    checks++; if (pop !== 4'b0100) begin failures++; $display("FAIL q2_pop got=%b exp=0100", pop); end
    enb = 1'b0;
    @(negedge clk);
    exp_count++;
    checks++; if (valid_out !== 1'b1 || data_out !== words[2] || pop_count !== exp_count) begin
      failures++; $display("FAIL q2_data got=%0b/%h/%0d exp=1/%h/%0d", valid_out, data_out, pop_count, words[2], exp_count); end
    @(negedge clk);
    checks++; if (valid_out !== 1'b0 || arb_enb !== 1'b0) begin failures++; $display("FAIL q2_release got=%0b/%0b exp=0/0", valid_out, arb_enb); end
    ready_in = 1'b0;
    buf_empty = '1;
    $display("txn single q=2 data=%h", words[2]);
  endtask

  task automatic test_hold_stall();
    int q;
    q = $urandom_range(0, QN-1);
    start_txn(q);
    exp_count++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (valid_out !== 1'b1 || data_out !== words[q] || pop !== '0 || arb_enb !== 1'b0 || pop_count !== exp_count) begin
        failures++; $display("FAIL hold_stable got=%0b/%h/%b/%0b/%0d exp=1/%h/0000/0/%0d", valid_out, data_out, pop, arb_enb, pop_count, words[q], exp_count); end
    end
    ready_in = 1'b1;
    enb = 1'b0;
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL hold_release got=%0b exp=0", valid_out); end
    ready_in = 1'b0;
    $display("txn hold_stall q=%0d data=%h", q, words[q]);
  endtask

  task automatic test_empty_race();
    int q;
    logic [QN-1:0] oh;
    q = $urandom_range(0, QN-1);
    oh = '0;
    oh[q] = 1'b1;
    load_words();
    buf_empty = ~oh;
    selector = SW'(q);
    selector_enb = 1'b1;
    enb = 1'b1;
    @(negedge clk);
    checks++; if (arb_enb !== 1'b1) begin failures++; $display("FAIL race_grant got=%0b exp=1", arb_enb); end
    buf_empty = '1;
    @(negedge clk);
    checks++; if (pop !== '0) begin failures++; $display("FAIL race_nopop got=%b exp=0000", pop); end
    @(negedge clk);
    checks++; if (arb_enb !== 1'b1 || pop_count !== exp_count) begin
      failures++; $display("FAIL race_regrant got=%0b/%0d exp=1/%0d", arb_enb, pop_count, exp_count); end
    enb = 1'b0;
    @(negedge clk);
    checks++; if (arb_enb !== 1'b0 || valid_out !== 1'b0) begin failures++; $display("FAIL race_idle got=%0b/%0b exp=0/0", arb_enb, valid_out); end
    $display("txn empty_race q=%0d", q);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int q, d;
      logic drop;
      logic [QN-1:0] oh;
      q = $urandom_range(0, QN-1);
      d = $urandom_range(0, 3);
      drop = 1'($urandom_range(0, 1));
      oh = '0;
      oh[q] = 1'b1;
      load_words();
      buf_empty = QN'($urandom) & ~oh;
      selector = SW'(q);
      selector_enb = 1'b1;
      enb = 1'b1;
      ready_in = 1'b0;
      @(negedge clk);
      checks++; if (arb_enb !== 1'b1 || pop !== '0) begin failures++; $display("FAIL rnd_grant t=%0d got=%0b/%b exp=1/0000", t, arb_enb, pop); end
      @(negedge clk);
      checks++; if (pop !== oh) begin failures++; $display("FAIL rnd_pop t=%0d got=%b exp=%b", t, pop, oh); end
      if (drop) enb = 1'b0;
      @(negedge clk);
      exp_count++;
      checks++; if (valid_out !== 1'b1 || data_out !== words[q] || pop_count !== exp_count) begin
        failures++; $display("FAIL rnd_data t=%0d got=%0b/%h/%0d exp=1/%h/%0d", t, valid_out, data_out, pop_count, words[q], exp_count); end
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        checks++; if (valid_out !== 1'b1 || data_out !== words[q] || pop !== '0 || arb_enb !== 1'b0) begin
          failures++; $display("FAIL rnd_hold t=%0d got=%0b/%h/%b/%0b exp=1/%h/0000/0", t, valid_out, data_out, pop, arb_enb, words[q]); end
      end
      ready_in = 1'b1;
      @(negedge clk);
      checks++; if (valid_out !== 1'b0 || arb_enb !== !drop) begin
        failures++; $display("FAIL rnd_exit t=%0d got=%0b/%0b exp=0/%0b", t, valid_out, arb_enb, !drop); end
      ready_in = 1'b0;
      enb = 1'b0;
      @(negedge clk);
      $display("txn random t=%0d q=%0d data=%h hold=%0d drop_enb=%0b", t, q, words[q], d, drop);
    end
    buf_empty = '1;
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] sel_hist [31];
    logic [QN-1:0] exp_pop;
    load_words();
    buf_empty = '0;
    enb = 1'b1;
    selector_enb = 1'b1;
    ready_in = 1'b1;
    sel_hist[0] = SW'($urandom);
    selector = sel_hist[0];
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      exp_pop = '0;
      if (k % 3 == 2) begin
        exp_pop[sel_hist[k-1]] = 1'b1;
        exp_count++;
      end
      checks++; if (pop !== exp_pop) begin failures++; $display("FAIL b2b_pop k=%0d got=%b exp=%b", k, pop, exp_pop); end
      if (k % 3 == 0) begin
        checks++; if (valid_out !== 1'b1 || data_out !== words[sel_hist[k-2]]) begin
          failures++; $display("FAIL b2b_data k=%0d got=%0b/%h exp=1/%h", k, valid_out, data_out, words[sel_hist[k-2]]); end
      end
      if (k % 3 == 1) begin
        checks++; if (arb_enb !== 1'b1 || valid_out !== 1'b0) begin
          failures++; $display("FAIL b2b_grant k=%0d got=%0b/%0b exp=1/0", k, arb_enb, valid_out); end
      end
      sel_hist[k] = SW'($urandom);
      selector = sel_hist[k];
    end
    enb = 1'b0;
    @(negedge clk);
    checks++; if (valid_out !== 1'b0 || pop_count !== exp_count) begin
      failures++; $display("FAIL b2b_end got=%0b/%0d exp=0/%0d", valid_out, pop_count, exp_count); end
    ready_in = 1'b0;
    buf_empty = '1;
    $display("txn back_to_back words=10 pop_count=%0d", exp_count);
  endtask

  task automatic test_mode_change();
    start_txn($urandom_range(0, QN-1));
    exp_count++;
    modo_req = 2'b01;
    modo_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      modo_req_valid = 1'b0;
      checks++; if (seleccion_roundRobin !== exp_mode || modo_ack !== 1'b0 || valid_out !== 1'b1) begin
        failures++; $display("FAIL mode_hold got=%b/%0b/%0b exp=%b/0/1", seleccion_roundRobin, modo_ack, valid_out, exp_mode); end
    end
    ready_in = 1'b1;
    enb = 1'b0;
    @(negedge clk);
    exp_mode = 2'b01;
    checks++; if (modo_ack !== 1'b1 || seleccion_roundRobin !== exp_mode || valid_out !== 1'b0) begin
      failures++; $display("FAIL mode_apply got=%0b/%b/%0b exp=1/%b/0", modo_ack, seleccion_roundRobin, valid_out, exp_mode); end
    ready_in = 1'b0;
    @(negedge clk);
    checks++; if (modo_ack !== 1'b0 || seleccion_roundRobin !== exp_mode) begin
      failures++; $display("FAIL mode_after got=%0b/%b exp=0/%b", modo_ack, seleccion_roundRobin, exp_mode); end
    $display("txn mode_change mode=%b", exp_mode);
    modo_req = 2'b10;
    modo_req_valid = 1'b1;
    @(negedge clk);
    modo_req = 2'b11;
    @(negedge clk);
    modo_req_valid = 1'b0;
    exp_mode = 2'b11;
    checks++; if (modo_ack !== 1'b1 || seleccion_roundRobin !== exp_mode) begin
      failures++; $display("FAIL mode_latest got=%0b/%b exp=1/%b", modo_ack, seleccion_roundRobin, exp_mode); end
    @(negedge clk);
    checks++; if (modo_ack !== 1'b0 || seleccion_roundRobin !== exp_mode) begin
      failures++; $display("FAIL mode_latest_after got=%0b/%b exp=0/%b", modo_ack, seleccion_roundRobin, exp_mode); end
    buf_empty = '1;
    $display("txn mode_change mode=%b", exp_mode);
  endtask

  task automatic test_reset_in_hold();
    start_txn($urandom_range(0, QN-1));
    exp_count++;
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL rsthold_pre got=%0b exp=1", valid_out); end
    modo_req = 2'b10;
    modo_req_valid = 1'b1;
    @(negedge clk);
    modo_req_valid = 1'b0;
    rst = 1'b0;
    enb = 1'b0;
    buf_empty = '1;
    @(negedge clk);
    exp_count = 16'h0;
    exp_mode = 2'b00;
    checks++; if (valid_out !== 1'b0 || data_out !== '0 || pop !== '0 || arb_enb !== 1'b0) begin
      failures++; $display("FAIL rsthold_data got=%0b/%h/%b/%0b exp=0/00/0000/0", valid_out, data_out, pop, arb_enb); end
    checks++; if (pop_count !== exp_count || modo_ack !== 1'b0 || seleccion_roundRobin !== exp_mode) begin
      failures++; $display("FAIL rsthold_misc got=%0d/%0b/%b exp=0/0/00", pop_count, modo_ack, seleccion_roundRobin); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (modo_ack !== 1'b0 || arb_enb !== 1'b0 || seleccion_roundRobin !== exp_mode) begin
      failures++; $display("FAIL rsthold_idle got=%0b/%0b/%b exp=0/0/00", modo_ack, arb_enb, seleccion_roundRobin); end
    $display("txn reset_in_hold");
  endtask

  task automatic test_wrap();
    int q;
    force dut.r_pop_count = 16'hFFFF;
    #1;
    release dut.r_pop_count;
    #1;
    exp_count = 16'hFFFF;
    checks++; if (pop_count !== exp_count) begin failures++; $display("FAIL wrap_preload got=%h exp=%h", pop_count, exp_count); end
    q = $urandom_range(0, QN-1);
    start_txn(q);
    exp_count++;
    checks++; if (pop_count !== exp_count || valid_out !== 1'b1 || data_out !== words[q]) begin
      failures++; $display("FAIL wrap_count got=%h/%0b/%h exp=%h/1/%h", pop_count, valid_out, data_out, exp_count, words[q]); end
    ready_in = 1'b1;
    enb = 1'b0;
    @(negedge clk);
    ready_in = 1'b0;
    buf_empty = '1;
    $display("txn wrap pop_count=%h", exp_count);
  endtask

  initial begin
    test_reset();
    test_single_queue2();
    test_hold_stall();
    test_empty_race();
    test_random();
    test_back_to_back();
    test_mode_change();
    test_reset_in_hold();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
